// File: rtl/tankb_vid_pkg.sv
// Shared types and defaults for the playfield VRAM slot arbiter.
package tankb_vid_pkg;

  localparam int VRAM_AW = 10;
  localparam int VRAM_DW = 8;

  // H[2:0] phase that opens the video tile fetch slot.
  localparam logic [2:0] FETCH_PHASE_DEF = 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2,
    ACK  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/vram_slot_decode.sv
// Decodes the horizontal phase and blanking flags into the video fetch slot.
// Build option VRAM_VBLANK_CPU_PRIORITY_EN suppresses fetch slots during vblank.
module vram_slot_decode
  import tankb_vid_pkg::*;
#(
  parameter logic [2:0] FETCH_PHASE = FETCH_PHASE_DEF
) (
  input  logic [2:0] h_phase,
  input  logic       hblank,
  input  logic       vblank,
  output logic       fetch_slot
);

`ifdef VRAM_VBLANK_CPU_PRIORITY_EN
  // Fetch slot only on visible lines outside vblank; the CPU owns every vblank slot.
  always_comb begin
    fetch_slot = (h_phase == FETCH_PHASE) & ~hblank & ~vblank;
  end
`else
  logic unused_vblank;
  assign unused_vblank = vblank;

  // Fetch slot on every line with hblank low, independent of vblank.
  always_comb begin
    fetch_slot = (h_phase == FETCH_PHASE) & ~hblank;
  end
`endif

endmodule

// File: rtl/vram_slot_arbiter.sv
// Shares the single-port playfield VRAM between the Z80 and the tile-fetch pipe.
// One slot is one pixel period; the video fetch has fixed priority, the CPU is
// held on cpu_wait until its slot completes. Build option:
// VRAM_VBLANK_CPU_PRIORITY_EN (no fetch slots during vblank, see vram_slot_decode).
module vram_slot_arbiter
  import tankb_vid_pkg::*;
#(
  parameter int         AW          = VRAM_AW,
  parameter int         DW          = VRAM_DW,
  parameter logic [2:0] FETCH_PHASE = FETCH_PHASE_DEF
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          pix_ce,
  input  logic [8:0]    h_cnt,
  input  logic [7:0]    v_cnt,
  input  logic          hblank,
  input  logic          vblank,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_wait,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] vram_addr,
  output logic          vram_we,
  output logic [DW-1:0] vram_wdata,
  input  logic [DW-1:0] vram_rdata,
  output logic [DW-1:0] tile_code,
  output logic          tile_stb
);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic          fetch_slot;
  logic [AW-1:0] vid_addr;
  logic [9:0]    tile_idx;
  logic          slot_end;

  // H256 and the sub-tile rows of V do not take part in addressing.
  logic [3:0] unused_cnt;
  assign unused_cnt = {h_cnt[8], v_cnt[2:0]};

  assign tile_idx = {v_cnt[7:3], h_cnt[7:3]};
  assign slot_end = pix_ce;

  vram_slot_decode #(
    .FETCH_PHASE (FETCH_PHASE)
  ) u_decode (
    .h_phase    (h_cnt[2:0]),
    .hblank     (hblank),
    .vblank     (vblank),
    .fetch_slot (fetch_slot)
  );

  // The CPU only counts as granted once its access has completed.
  assign cpu_wait = cpu_req & (state != ACK);

  // State register; moves only at pixel-slot boundaries.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state: fetch beats CPU in IDLE; a CPU request waiting behind a fetch
  // takes the very next slot; a request still held in ACK is not re-served.
  always_comb begin
    state_nxt = state;
    if (slot_end) begin
      case (state)
        IDLE: begin
          if (fetch_slot)   state_nxt = VID;
          else if (cpu_req) state_nxt = CPU;
        end
        VID:     state_nxt = cpu_req ? CPU : IDLE;
        CPU:     state_nxt = ACK;
        ACK:     if (!cpu_req) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // RAM port mux; the write strobe is confined to the single pix_ce clock of the CPU slot.
  always_comb begin
    vram_addr  = '0;
    vram_wdata = '0;
    vram_we    = 1'b0;
    case (state)
      VID: vram_addr = vid_addr;
      CPU: begin
        vram_addr  = cpu_addr;
        vram_wdata = cpu_wdata;
        vram_we    = cpu_we & pix_ce;
      end
      default: ;
    endcase
  end

  // Tile index captured when the fetch slot opens so it is stable for the whole slot.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET)                                     vid_addr <= '0;
    else if (slot_end && state == IDLE && fetch_slot) vid_addr <= AW'(tile_idx);
  end

  // Tile code capture and strobe at the end of the fetch slot.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      tile_code <= '0;
      tile_stb  <= 1'b0;
    end else begin
      tile_stb <= slot_end && state == VID;
      if (slot_end && state == VID) tile_code <= vram_rdata;
    end
  end

  // CPU completion: one-clock ack, read data held until the next CPU read.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= slot_end && state == CPU;
      if (slot_end && state == CPU && !cpu_we) cpu_rdata <= vram_rdata;
    end
  end

endmodule
